// File: rtl/puf_challenger_pkg.sv
// Shared definitions for the PUF challenger block.
//   state_t        : challenger FSM states
//   N_CHAL         : challenges per evaluation (one response bit each)
//   HOLD_CYCLES    : cycles the frozen PUF outputs get to cross the synchronizer
//   WINDOW_DEFAULT : default counting window in clock cycles
//   resp_match()   : masked compare of a response against the stored reference
package puf_challenger_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_COUNT  = 3'd2,
        S_HOLD   = 3'd3,
        S_SAMPLE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int N_CHAL         = 4;
    localparam int HOLD_CYCLES    = 3;
    localparam int WINDOW_DEFAULT = 8;

    // A bit only counts toward a mismatch when neither the fresh response nor
    // the enrolled reference flagged it as a tie.
    function automatic logic resp_match(input logic [3:0] resp,
                                        input logic [3:0] unst,
                                        input logic [3:0] ref_resp,
                                        input logic [3:0] ref_mask);
        return ((resp ^ ref_resp) & ~(unst | ref_mask)) == 4'b0000;
    endfunction

endpackage

// File: rtl/puf_challenger_sync2.sv
// Two-flop synchronizer for one asynchronous level signal.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/puf_challenger.sv
// Ring-oscillator PUF challenger. Runs four challenges (SEL = 0..3); for each
// one it clears the PUF counters, lets them count for WINDOW cycles, waits for
// the frozen result to cross the synchronizers and samples one response bit.
// Enroll mode stores the response as reference; verify mode compares to it.
//
// Ports:
//   CLK, RESET  : clock, asynchronous active-high reset
//   START, MODE : run request and mode (0 enroll, 1 verify), sampled in IDLE
//   PUF_BIT     : asynchronous PUF comparison result
//   PUF_TIE     : asynchronous PUF "counts equal" flag
//   PUF_EN      : oscillator/counter enable to the PUF
//   PUF_RESET   : counter clear to the PUF
//   SEL         : challenge index to the oscillator multiplexers
//   RESP        : assembled response, bit i from challenge i
//   UNSTABLE    : bit i set when challenge i tied
//   RESP_VALID  : one-cycle pulse when RESP/UNSTABLE/MATCH are final
//   MATCH       : verify result (always 1 after enroll), held until next run end
//   BUSY        : high whenever the FSM is not in IDLE
//   state_dbg   : current FSM state encoding
//
// Handshake: a run is accepted on a rising CLK edge where START=1 and BUSY=0;
// START is ignored while BUSY=1. Each accepted run produces exactly one
// RESP_VALID pulse, and outputs qualified by it are valid only in that cycle
// (MATCH additionally holds its value afterwards).
module puf_challenger
    import puf_challenger_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEFAULT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       MODE,
    input  logic       PUF_BIT,
    input  logic       PUF_TIE,
    output logic       PUF_EN,
    output logic       PUF_RESET,
    output logic [1:0] SEL,
    output logic [3:0] RESP,
    output logic [3:0] UNSTABLE,
    output logic       RESP_VALID,
    output logic       MATCH,
    output logic       BUSY,
    output logic [2:0] state_dbg
);

    localparam logic [7:0] WIN_LAST  = 8'(WINDOW - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [1:0] IDX_LAST  = 2'(N_CHAL - 1);

    state_t     state, state_nx;
    logic [7:0] cnt;
    logic [1:0] idx;
    logic       mode_q;
    logic       bit_s, tie_s;
    logic [3:0] resp_q, unst_q;
    logic [3:0] ref_resp, ref_mask;
    logic       match_q, match_now;

    sync2 u_sync_bit (.clk(CLK), .rst(RESET), .d(PUF_BIT), .q(bit_s));
    sync2 u_sync_tie (.clk(CLK), .rst(RESET), .d(PUF_TIE), .q(tie_s));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        PUF_EN     = 1'b0;
        PUF_RESET  = 1'b0;
        RESP_VALID = 1'b0;
        BUSY       = 1'b1;
        case (state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (START) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                PUF_RESET = 1'b1;
                state_nx  = S_COUNT;
            end
            S_COUNT: begin
                PUF_EN = 1'b1;
                if (cnt == WIN_LAST) state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) state_nx = S_SAMPLE;
            end
            S_SAMPLE: begin
                state_nx = (idx == IDX_LAST) ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                RESP_VALID = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Cycles spent in the current state; restarts on every state change so
    // COUNT and HOLD can time themselves from zero.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                  cnt <= 8'd0;
        else if (state_nx != state) cnt <= 8'd0;
        else                        cnt <= cnt + 8'd1;
    end

    // idx only moves on the transitions into CLEAR (IDLE->CLEAR resets it,
    // SAMPLE->CLEAR advances it), which keeps SEL stable across a challenge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            idx      <= 2'd0;
            mode_q   <= 1'b0;
            resp_q   <= 4'd0;
            unst_q   <= 4'd0;
            ref_resp <= 4'd0;
            ref_mask <= 4'd0;
            match_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        idx    <= 2'd0;
                        mode_q <= MODE;
                    end
                end
                S_SAMPLE: begin
                    resp_q[idx] <= bit_s;
                    unst_q[idx] <= tie_s;
                    if (idx != IDX_LAST) idx <= idx + 2'd1;
                end
                S_DONE: begin
                    match_q <= match_now;
                    if (!mode_q) begin
                        ref_resp <= resp_q;
                        ref_mask <= unst_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign match_now = mode_q ? resp_match(resp_q, unst_q, ref_resp, ref_mask) : 1'b1;

    // MATCH is live during DONE (same cycle as RESP_VALID) and held afterwards.
    assign MATCH     = (state == S_DONE) ? match_now : match_q;
    assign SEL       = idx;
    assign RESP      = resp_q;
    assign UNSTABLE  = unst_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_puf_challenger.sv
module tb_puf_challenger;

  localparam int NI = 3;
  localparam int EW = 23;

  // clock/reset
  logic clk;
  logic rst;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals, one set per instance (WINDOW = 8, 1, 255)
  int         ws[NI] = '{8, 1, 255};
  logic       start_v[NI];
  logic       mode_v[NI];
  logic       puf_bit_v[NI];
  logic       puf_tie_v[NI];
  logic       en_v[NI];
  logic       rstp_v[NI];
  logic [1:0] sel_v[NI];
  logic [3:0] resp_v[NI];
  logic [3:0] unst_v[NI];
  logic       valid_v[NI];
  logic       match_v[NI];
  logic       busy_v[NI];
  logic [2:0] st_v[NI];

  // PUF model: response bit / tie flag per challenge index
  logic [3:0] pat_bit;
  logic [3:0] pat_tie;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    puf_challenger #(.WINDOW(g == 0 ? 8 : (g == 1 ? 1 : 255))) dut (
      .CLK        (clk),
      .RESET      (rst),
      .START      (start_v[g]),
      .MODE       (mode_v[g]),
      .PUF_BIT    (puf_bit_v[g]),
      .PUF_TIE    (puf_tie_v[g]),
      .PUF_EN     (en_v[g]),
      .PUF_RESET  (rstp_v[g]),
      .SEL        (sel_v[g]),
      .RESP       (resp_v[g]),
      .UNSTABLE   (unst_v[g]),
      .RESP_VALID (valid_v[g]),
      .MATCH      (match_v[g]),
      .BUSY       (busy_v[g]),
      .state_dbg  (st_v[g])
    );
    assign puf_bit_v[g] = pat_bit[sel_v[g]];
    assign puf_tie_v[g] = pat_tie[sel_v[g]];
  end

  // scoreboard: {tag[1:0], latency[11:0], resp[3:0], unstable[3:0], match}
  logic [EW-1:0] exp_q[$];
  int            start_cyc[NI];
  int            total;
  int            bad;
  logic          zero_chk;
  logic          drain_chk;

  // monitor-side state
  int            en_run[NI];
  int            rst_run[NI];
  int            chal_n[NI];
  logic [1:0]    sel_prev[NI];
  logic [EW-1:0] mon_e;
  logic          mon_rise;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (zero_chk) begin
      for (int i = 0; i < NI; i++) begin
        chk("rst_puf_en", int'(en_v[i]), 0);
        chk("rst_puf_reset", int'(rstp_v[i]), 0);
        chk("rst_sel", int'(sel_v[i]), 0);
        chk("rst_resp", int'(resp_v[i]), 0);
        chk("rst_unstable", int'(unst_v[i]), 0);
        chk("rst_resp_valid", int'(valid_v[i]), 0);
        chk("rst_match", int'(match_v[i]), 0);
        chk("rst_busy", int'(busy_v[i]), 0);
      end
    end
    if (drain_chk) begin
      chk("queue_drained", exp_q.size(), 0);
      exp_q.delete();
    end
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        en_run[i]  = 0;
        rst_run[i] = 0;
        chal_n[i]  = 0;
      end else begin
        chk("en_rst_exclusive", int'(en_v[i] & rstp_v[i]), 0);
        mon_rise = rstp_v[i] && (rst_run[i] == 0);
        if (mon_rise) begin
          chk("sel_sequence", int'(sel_v[i]), chal_n[i] % 4);
          chal_n[i]++;
        end else begin
          chk("sel_stable", int'(sel_v[i]), int'(sel_prev[i]));
        end
        if (rstp_v[i]) rst_run[i]++;
        else if (rst_run[i] > 0) begin
          chk("puf_reset_len", rst_run[i], 1);
          rst_run[i] = 0;
        end
        if (en_v[i]) en_run[i]++;
        else if (en_run[i] > 0) begin
          chk("puf_en_len", en_run[i], ws[i]);
          en_run[i] = 0;
        end
      end
      if (valid_v[i]) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got pulse on inst %0d expected none", i);
        end else begin
          mon_e = exp_q.pop_front();
          chk("inst", i, int'(mon_e[22:21]));
          chk("latency", cyc - start_cyc[i] + 1, int'(mon_e[20:9]));
          chk("resp", int'(resp_v[i]), int'(mon_e[8:5]));
          chk("unstable", int'(unst_v[i]), int'(mon_e[4:1]));
          chk("match", int'(match_v[i]), int'(mon_e[0]));
        end
      end
      sel_prev[i] = sel_v[i];
    end
  end

  // driver tasks: all stimulus changes land 2 time units after a rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input int i, input int lat, input logic [3:0] r,
                          input logic [3:0] u, input logic m);
    exp_q.push_back({2'(i), 12'(lat), r, u, m});
  endtask

  task automatic issue(input int i, input logic md, input logic [3:0] pb,
                       input logic [3:0] pt);
    pat_bit      = pb;
    pat_tie      = pt;
    mode_v[i]    = md;
    start_v[i]   = 1'b1;
    start_cyc[i] = cyc + 1;
    tick();
    start_v[i] = 1'b0;
  endtask

  task automatic finish_run(input int budget, input int extra);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    repeat (extra) tick();
    drain_chk = 1'b1;
    tick();
    drain_chk = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    cyc       = 0;
    zero_chk  = 1'b1;
    drain_chk = 1'b0;
    pat_bit   = 4'b0000;
    pat_tie   = 4'b0000;
    for (int i = 0; i < NI; i++) begin
      start_v[i]   = 1'b0;
      mode_v[i]    = 1'b0;
      start_cyc[i] = 0;
      en_run[i]    = 0;
      rst_run[i]   = 0;
      chal_n[i]    = 0;
      sel_prev[i]  = 2'd0;
    end
    rst = 1'b1;
    tick();
    tick();
    zero_chk = 1'b0;
    rst      = 1'b0;
    repeat (3) tick();

    // enroll: bits 1,0,1,1 for SEL 0..3
    push_exp(0, 53, 4'b1101, 4'b0000, 1'b1);
    issue(0, 1'b0, 4'b1101, 4'b0000);
    finish_run(100, 3);

    // verify, same response
    push_exp(0, 53, 4'b1101, 4'b0000, 1'b1);
    issue(0, 1'b1, 4'b1101, 4'b0000);
    finish_run(100, 3);

    // verify, challenge 2 flipped
    push_exp(0, 53, 4'b1001, 4'b0000, 1'b0);
    issue(0, 1'b1, 4'b1001, 4'b0000);
    finish_run(100, 3);

    // verify, challenge 2 flipped but tied -> masked
    push_exp(0, 53, 4'b1001, 4'b0100, 1'b1);
    issue(0, 1'b1, 4'b1001, 4'b0100);
    finish_run(100, 3);

    // START (with MODE=enroll) while busy must be ignored
    push_exp(0, 53, 4'b1001, 4'b0000, 1'b0);
    issue(0, 1'b1, 4'b1001, 4'b0000);
    repeat (18) tick();
    mode_v[0]  = 1'b0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    finish_run(100, 70);

    // reference must still be the enrolled 1101
    push_exp(0, 53, 4'b1101, 4'b0000, 1'b1);
    issue(0, 1'b1, 4'b1101, 4'b0000);
    finish_run(100, 3);

    // reset during COUNT of challenge 2
    issue(0, 1'b1, 4'b1101, 4'b0000);
    repeat (29) tick();
    rst      = 1'b1;
    zero_chk = 1'b1;
    tick();
    zero_chk = 1'b0;
    rst      = 1'b0;
    repeat (2) tick();

    // after reset the reference is 0
    push_exp(0, 53, 4'b1101, 4'b0000, 1'b0);
    issue(0, 1'b1, 4'b1101, 4'b0000);
    finish_run(100, 3);
    push_exp(0, 53, 4'b0000, 4'b0000, 1'b1);
    issue(0, 1'b1, 4'b0000, 4'b0000);
    finish_run(100, 3);

    // WINDOW=1 and WINDOW=255 instances
    push_exp(1, 25, 4'b0110, 4'b0000, 1'b1);
    issue(1, 1'b0, 4'b0110, 4'b0000);
    finish_run(60, 3);
    push_exp(2, 1041, 4'b1010, 4'b0000, 1'b1);
    issue(2, 1'b0, 4'b1010, 4'b0000);
    finish_run(1200, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
